// File: rtl/phase_seq_pkg.sv
// Shared types, default parameters and helpers for the phase sequencer.
package phase_seq_pkg;

  typedef enum logic {StIdle, StRun} seq_state_e;

  localparam int unsigned DefNumPhases = 4;
  localparam int unsigned DefPhWidth   = 2;
  localparam int unsigned DefCntWidth  = 8;
  localparam int unsigned DefDivN      = 10;
  localparam int unsigned DefDivWidth  = 4;

  // A programmed length of zero still occupies one tick.
  function automatic int unsigned eff_len(input int unsigned len);
    return (len == 0) ? 1 : len;
  endfunction

endpackage

// File: rtl/seq_prescaler.sv
// Mod-DIV_N tick prescaler with synchronous clear and enable.
module seq_prescaler
  import phase_seq_pkg::*;
#(
  parameter int unsigned DIV_N     = DefDivN,
  parameter int unsigned DIV_WIDTH = DefDivWidth
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam logic [DIV_WIDTH-1:0] CntMax = DIV_WIDTH'(DIV_N - 1);

  logic [DIV_WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= (count_q == CntMax) ? '0 : count_q + DIV_WIDTH'(1);
    end
  end

  assign tick = en && (count_q == CntMax);

endmodule

// File: rtl/phase_sequencer.sv
// Programmable multi-phase timing controller: steps through NUM_PHASES phases of
// per-phase length in prescaled ticks, with loop, abort and done reporting.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned NUM_PHASES = DefNumPhases,
  parameter int unsigned PH_WIDTH   = DefPhWidth,
  parameter int unsigned CNT_WIDTH  = DefCntWidth,
  parameter int unsigned DIV_N      = DefDivN,
  parameter int unsigned DIV_WIDTH  = DefDivWidth
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            loop,
  input  logic [NUM_PHASES*CNT_WIDTH-1:0] phase_len,
  output logic                            busy,
  output logic [PH_WIDTH-1:0]             phase,
  output logic                            phase_start,
  output logic [CNT_WIDTH-1:0]            elapsed,
  output logic                            done
);

  seq_state_e           state_q;
  logic                 busy_q, phase_start_q, done_q;
  logic [PH_WIDTH-1:0]  phase_q;
  logic [CNT_WIDTH-1:0] elapsed_q;
  logic [CNT_WIDTH-1:0] shadow_q [NUM_PHASES];

  logic                 tick, phase_end, last_phase, presc_clear, presc_en;
  logic [CNT_WIDTH-1:0] cur_len, last_cnt;

  assign cur_len     = shadow_q[phase_q];
  assign last_cnt    = CNT_WIDTH'(eff_len(32'(cur_len)) - 32'd1);
  assign last_phase  = (phase_q == PH_WIDTH'(NUM_PHASES - 1));
  assign presc_en    = (state_q == StRun);
  assign phase_end   = presc_en && tick && (elapsed_q == last_cnt);
  // Restart the prescaler at every phase boundary and hold it at zero while idle.
  assign presc_clear = (state_q == StIdle) || phase_end;

  seq_prescaler #(
    .DIV_N    (DIV_N),
    .DIV_WIDTH(DIV_WIDTH)
  ) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(presc_clear),
    .en   (presc_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      phase_q       <= '0;
      elapsed_q     <= '0;
      phase_start_q <= 1'b0;
      done_q        <= 1'b0;
      for (int k = 0; k < NUM_PHASES; k++) shadow_q[k] <= '0;
    end else begin
      phase_start_q <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            state_q       <= StRun;
            busy_q        <= 1'b1;
            phase_q       <= '0;
            elapsed_q     <= '0;
            phase_start_q <= 1'b1;
            for (int k = 0; k < NUM_PHASES; k++) begin
              shadow_q[k] <= phase_len[k*CNT_WIDTH +: CNT_WIDTH];
            end
          end
        end
        StRun: begin
          if (abort) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            phase_q   <= '0;
            elapsed_q <= '0;
          end else if (phase_end) begin
            elapsed_q <= '0;
            if (!last_phase) begin
              phase_q       <= phase_q + PH_WIDTH'(1);
              phase_start_q <= 1'b1;
            end else if (loop) begin
              phase_q       <= '0;
              phase_start_q <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
              phase_q <= '0;
              done_q  <= 1'b1;
            end
          end else if (tick) begin
            elapsed_q <= elapsed_q + CNT_WIDTH'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy        = busy_q;
  assign phase       = phase_q;
  assign phase_start = phase_start_q;
  assign elapsed     = elapsed_q;
  assign done        = done_q;

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

- Programmable multi-phase timing controller.
- Steps through up to NUM_PHASES phases. Each phase lasts a programmed number of prescaled ticks.
- Ticks come from an internal mod-DIV_N prescaler.
- Sits above the mod-N counter datapath and sequences it: starts it, clears it, reloads per-phase terminal counts.
- Reports phase index, phase-start pulses and run completion to downstream control logic.

## Interface
- NUM_PHASES, default 4: number of phases per run (≥2).
- PH_WIDTH, default 2: width of phase index; must represent NUM_PHASES-1.
- CNT_WIDTH, default 8: width of each phase length and of the elapsed-tick count.
- DIV_N, default 10: prescaler modulus in clock cycles per tick (≥1).
- DIV_WIDTH, default 4: prescaler width; must represent DIV_N-1.
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request a run; honoured only when idle.
- abort  in  1  terminate a run immediately; no done pulse.
- loop  in  1  at end of last phase: 1 = restart at phase 0, 0 = finish.
- phase_len  in  NUM_PHASES*CNT_WIDTH  packed lengths in ticks; phase k at bits [k*CNT_WIDTH +: CNT_WIDTH].
- busy  out  1  high while a run is active.
- phase  out  PH_WIDTH  current phase index.
- phase_start  out  1  one-cycle pulse in the first cycle of every phase.
- elapsed  out  CNT_WIDTH  ticks completed in the current phase.
- done  out  1  one-cycle pulse when a non-looping run completes.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE→RUN when start=1 and abort=0.
  - All NUM_PHASES lengths are captured into shadow registers at this point.
  - phase_len changes mid-run have no effect.
- Effective length is L_k = phase_len_k, except a programmed 0 is treated as 1.
- Prescaler, in RUN only:
  - Counts 0..DIV_N-1 and wraps.
  - tick=1 in the cycle where prescaler==DIV_N-1.
  - Cleared to 0 in IDLE and on every phase change.
- elapsed increments on tick.
- When tick=1 and elapsed==L_k-1, the phase ends:
  - Not last phase: phase←k+1, elapsed←0, phase_start=1 next cycle.
  - Last phase, loop=1 (loop sampled in that cycle): phase←0, elapsed←0, phase_start=1; shadow lengths are not reloaded.
  - Last phase, loop=0: RUN→IDLE, done=1 next cycle, phase←0, elapsed←0.
- abort=1 in RUN: next cycle IDLE, busy=0, phase=0, elapsed=0, no done or phase_start.
- abort has priority over a simultaneous phase end.
- start while busy is ignored.
- abort in IDLE has no effect; abort with start in IDLE leaves the block idle.
- Arithmetic: elapsed never exceeds L_k-1 and never wraps. Phase index wraps only via the loop rule.

## Timing
- Reset (rst_n=0 at an edge): state IDLE, busy=0, phase=0, elapsed=0, phase_start=0, done=0, prescaler=0, shadow lengths=0.
- Reset mid-run takes effect at the next edge with no done pulse.
- start sampled at edge t:
  - At t+1: busy=1, phase=0, phase_start=1, elapsed=0.
- Phase k occupies exactly L_k*DIV_N consecutive cycles.
- A non-looping run ends as follows:
  - busy falls in the cycle after the last tick.
  - done is high for that single cycle.
  - That cycle is IDLE, so a start in that cycle is accepted.
- DIV_N=1: tick every RUN cycle; a phase with L=1 lasts one cycle.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `phase_seq_pkg` holds:
  - state encoding (IDLE, RUN)
  - default parameter constants
  - a helper function for effective length (0→1)
- One sub-module, `seq_prescaler`:
  - mod-DIV_N counter with synchronous active-low reset
  - synchronous clear and enable inputs
  - registered-free tick output, valid in the same cycle as count==DIV_N-1
- Top level holds the FSM, shadow length registers, and the phase/elapsed counters.

## Test plan
- Basic run, DIV_N=2, lengths {3,1,2,4}, loop=0, start at cycle 0:
  - phase_start at cycles 1, 7, 9, 13.
  - done at cycle 21; busy high for cycles 1–20.
- Zero length, lengths {0,2,0,1}, DIV_N=1:
  - Phases last 1, 2, 1, 1 cycles.
  - done 5 cycles after busy rises.
- Loop, same lengths as the basic run with loop=1:
  - After phase 3, phase returns to 0 with phase_start and no done.
  - Drop loop during the second pass: done follows the end of phase 3.
- Abort:
  - abort in phase 2, cycle 10: next cycle busy=0, phase=0, elapsed=0, no done.
  - abort in the same cycle as the last tick: no done pulse.
- Start while busy and back-to-back:
  - start pulses mid-run are ignored and the run timing is unchanged.
  - start in the done cycle: new run begins with phase_start the following cycle.
- Reset and shadowing:
  - rst_n low mid-phase: all outputs 0 next cycle.
  - Change phase_len mid-run: durations still follow the lengths captured at start.
